// File: rtl/blit_pkg.sv
// Shared types and defaults for the rectangular blit copy engine.
package blit_pkg;
    localparam int SRC_AW = 20;
    localparam int DW     = 16;
    localparam int CW     = 10;

    localparam int             SCREEN_W_DEF = 640;
    localparam int             SCREEN_H_DEF = 480;
    localparam int             SRC_LAT_DEF  = 2;
    localparam int             QDEPTH_DEF   = 4;
    localparam logic [DW-1:0]  KEY_DEF      = 16'h0000;

    typedef struct packed {
        logic [SRC_AW-1:0] src;
        logic [CW-1:0]     w;
        logic [CW-1:0]     h;
        logic [CW-1:0]     x;
        logic [CW-1:0]     y;
        logic              key_en;
    } blit_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } blit_state_t;

    typedef struct packed {
        logic          valid;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          inb;
        logic          last;
    } pipe_tag_t;
endpackage

// File: rtl/blit_sequencer_if.sv
// Command, source-read and frame-buffer write signals of the blit sequencer.
interface blit_sequencer_if;
    import blit_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [SRC_AW-1:0] cmd_src;
    logic [CW-1:0]     cmd_w;
    logic [CW-1:0]     cmd_h;
    logic [CW-1:0]     cmd_x;
    logic [CW-1:0]     cmd_y;
    logic              cmd_key_en;
    logic              abort;
    logic [SRC_AW-1:0] src_addr;
    logic [DW-1:0]     src_data;
    logic [CW-1:0]     program_x;
    logic [CW-1:0]     program_y;
    logic [DW-1:0]     program_data;
    logic              program_write;
    logic              busy;
    logic              blit_done;

    modport master (
        output cmd_valid, cmd_src, cmd_w, cmd_h, cmd_x, cmd_y, cmd_key_en, abort, src_data,
        input  cmd_ready, src_addr, program_x, program_y, program_data, program_write,
               busy, blit_done
    );

    modport slave (
        input  cmd_valid, cmd_src, cmd_w, cmd_h, cmd_x, cmd_y, cmd_key_en, abort, src_data,
        output cmd_ready, src_addr, program_x, program_y, program_data, program_write,
               busy, blit_done
    );
endinterface

// File: rtl/blit_cmd_fifo.sv
// Command queue: synchronous FIFO of blit_cmd_t, head visible combinationally.
// Flush wins over a same-cycle push; push and pop together keep the count.
module blit_cmd_fifo
    import blit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_flush,
    input  logic      i_push,
    input  blit_cmd_t i_push_dat,
    input  logic      i_pop,
    output blit_cmd_t o_head,
    output logic      o_empty,
    output logic      o_full
);
    localparam int AW = $clog2(DEPTH);

    blit_cmd_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [AW:0]     r_cnt;
    logic            w_push;
    logic            w_pop;

    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_head  = r_mem[r_rp];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_push_dat;
    end
endmodule

// File: rtl/blit_sequencer.sv
// Queued rectangular blit engine: one source read per cycle, frame-buffer write SRC_LAT+1 later.
// Clips at the screen edges, drops key-coloured pixels; cmd_ready falls when the queue is full.
module blit_sequencer
    import blit_pkg::*;
#(
    parameter int            SCREEN_W = SCREEN_W_DEF,
    parameter int            SCREEN_H = SCREEN_H_DEF,
    parameter int            SRC_LAT  = SRC_LAT_DEF,
    parameter int            QDEPTH   = QDEPTH_DEF,
    parameter logic [DW-1:0] KEY      = KEY_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    blit_sequencer_if.slave  bus
);
    blit_state_t       r_state, w_state_nxt;
    blit_cmd_t         r_cmd, w_head, w_push_cmd;
    logic              w_empty, w_full, w_pop, w_issue;
    logic [CW-1:0]     r_col, r_row;
    logic [SRC_AW-1:0] r_row_base, r_src_addr, w_rd_addr;
    logic              w_col_end, w_last;
    logic [CW:0]       w_xc, w_yr;
    pipe_tag_t         r_pipe [SRC_LAT];
    pipe_tag_t         w_tag_in, w_exit;
    logic              w_pipe_busy, w_wr;
    logic              r_prog_wr, r_exit_last;
    logic [CW-1:0]     r_prog_x, r_prog_y;
    logic [DW-1:0]     r_prog_data;

    assign w_push_cmd = '{src: bus.cmd_src, w: bus.cmd_w, h: bus.cmd_h,
                          x: bus.cmd_x, y: bus.cmd_y, key_en: bus.cmd_key_en};
    assign w_pop      = (r_state == S_IDLE) && !w_empty && !bus.abort;

    blit_cmd_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (bus.abort),
        .i_push     (bus.cmd_valid),
        .i_push_dat (w_push_cmd),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    assign w_col_end = (r_col == r_cmd.w - CW'(1));
    assign w_last    = w_col_end && (r_row == r_cmd.h - CW'(1));
    assign w_rd_addr = r_row_base + SRC_AW'(r_col);
    assign w_xc      = {1'b0, r_cmd.x} + {1'b0, r_col};
    assign w_yr      = {1'b0, r_cmd.y} + {1'b0, r_row};

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = (r_cmd.w == '0 || r_cmd.h == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                w_issue = 1'b1;
                if (w_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: if (r_exit_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Row stepping adds w to the row base, so no multiplier is needed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cmd      <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            r_src_addr <= '0;
        end else begin
            if (w_pop) r_cmd <= w_head;
            if (r_state == S_LOAD) begin
                r_col      <= '0;
                r_row      <= '0;
                r_row_base <= r_cmd.src;
            end else if (w_issue) begin
                r_src_addr <= w_rd_addr;
                if (w_col_end) begin
                    r_col      <= '0;
                    r_row      <= r_row + 1'b1;
                    r_row_base <= r_row_base + SRC_AW'(r_cmd.w);
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_tag_in.valid = w_issue;
        w_tag_in.x     = w_xc[CW-1:0];
        w_tag_in.y     = w_yr[CW-1:0];
        w_tag_in.inb   = (w_xc < (CW+1)'(SCREEN_W)) && (w_yr < (CW+1)'(SCREEN_H));
        w_tag_in.last  = w_last;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || bus.abort) begin
            for (int i = 0; i < SRC_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_tag_in;
            for (int i = 1; i < SRC_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < SRC_LAT; i++) w_pipe_busy = w_pipe_busy | r_pipe[i].valid;
    end

    assign w_exit = r_pipe[SRC_LAT-1];
    assign w_wr   = w_exit.valid && w_exit.inb && !(r_cmd.key_en && bus.src_data == KEY);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prog_wr   <= 1'b0;
            r_exit_last <= 1'b0;
            r_prog_x    <= '0;
            r_prog_y    <= '0;
            r_prog_data <= '0;
        end else if (bus.abort) begin
            r_prog_wr   <= 1'b0;
            r_exit_last <= 1'b0;
        end else begin
            r_prog_wr   <= w_wr;
            r_exit_last <= w_exit.valid && w_exit.last;
            if (w_wr) begin
                r_prog_x    <= w_exit.x;
                r_prog_y    <= w_exit.y;
                r_prog_data <= bus.src_data;
            end
        end
    end

    assign bus.cmd_ready     = !w_full;
    assign bus.src_addr      = (r_state == S_RUN) ? w_rd_addr : r_src_addr;
    assign bus.program_x     = r_prog_x;
    assign bus.program_y     = r_prog_y;
    assign bus.program_data  = r_prog_data;
    assign bus.program_write = r_prog_wr;
    assign bus.busy          = !w_empty || (r_state != S_IDLE) || w_pipe_busy;
    assign bus.blit_done     = (r_state == S_DONE);
endmodule

// File: tb/tb_blit_sequencer.sv
// Bench for blit_sequencer: directed cases plus random commands against a pixel-list model.
module tb_blit_sequencer;
    import blit_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    blit_sequencer_if bus ();

    blit_sequencer #(
        .SCREEN_W (640),
        .SCREEN_H (480),
        .SRC_LAT  (LAT),
        .QDEPTH   (4),
        .KEY      (16'h0000)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        int          x;
        int          y;
        logic [15:0] d;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [4096];
    logic [19:0] exp_rd [$];
    wr_t         exp_wr [$];
    int          exp_done [$];
    logic [19:0] hist [$];
    logic [19:0] prev_addr = '0;
    logic [19:0] last_end = '0;
    int          cmd_id = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          last_wr_cyc = 0;
    int          last_done_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: every pixel of the rectangle in raster order, clipped and keyed.
    task automatic model_cmd(input logic [19:0] src, input int w, input int h,
                             input int x, input int y, input logic key);
        logic [19:0] a;
        logic [15:0] d;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                a = src + 20'(r * w + c);
                exp_rd.push_back(a);
                d = mem[a[11:0]];
                if (x + c < 640 && y + r < 480 && !(key && d == 16'h0000))
                    exp_wr.push_back('{cmd_id, x + c, y + r, d});
            end
        end
        if (w > 0 && h > 0) last_end = src + 20'(w * h - 1);
        exp_done.push_back(cmd_id);
        cmd_id++;
    endtask

    task automatic push(input logic [19:0] src, input int w, input int h,
                        input int x, input int y, input logic key);
        int n = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_src    = src;
        bus.cmd_w      = 10'(w);
        bus.cmd_h      = 10'(h);
        bus.cmd_x      = 10'(x);
        bus.cmd_y      = 10'(y);
        bus.cmd_key_en = key;
        while (!bus.cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("push_timeout", bus.cmd_ready, 1);
        else begin
            @(posedge clk);
            model_cmd(src, w, h, x, y, key);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || exp_done.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", exp_done.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [19:0] a;
        int          id;
        logic        pend;
        wr_t         ew;
        cyc++;
        if (!rst) begin
            if (bus.src_addr !== prev_addr) begin
                if (exp_rd.size() == 0) chk("rd_unexp", bus.src_addr, prev_addr);
                else chk("rd_addr", bus.src_addr, exp_rd.pop_front());
                prev_addr = bus.src_addr;
            end
            if (bus.program_write) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (exp_wr.size() == 0) chk("wr_unexp", bus.program_write, 0);
                else begin
                    ew = exp_wr.pop_front();
                    chk("wr_x", bus.program_x, ew.x);
                    chk("wr_y", bus.program_y, ew.y);
                    chk("wr_data", bus.program_data, ew.d);
                end
            end
            if (bus.blit_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                if (exp_done.size() == 0) chk("done_unexp", bus.blit_done, 0);
                else begin
                    id   = exp_done.pop_front();
                    pend = (exp_wr.size() > 0) && (exp_wr[0].id == id);
                    chk("done_early", pend, 0);
                end
            end
        end
        hist.push_back(bus.src_addr);
        if (hist.size() > LAT) begin
            a = hist.pop_front();
            bus.src_data = mem[a[11:0]];
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          sw, sd, k, w, h, x, y;
        logic [19:0] src;
        bus.cmd_valid  = 1'b0;
        bus.cmd_src    = '0;
        bus.cmd_w      = '0;
        bus.cmd_h      = '0;
        bus.cmd_x      = '0;
        bus.cmd_y      = '0;
        bus.cmd_key_en = 1'b0;
        bus.abort      = 1'b0;
        bus.src_data   = '0;
        for (int i = 0; i < 4096; i++)
            mem[i] = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
        for (int i = 0; i < 6; i++) mem[256 + i] = 16'h1000 + 16'(i);

        repeat (3) @(negedge clk);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_write", bus.program_write, 0);
        chk("rst_done", bus.blit_done, 0);
        chk("rst_addr", bus.src_addr, 0);
        chk("rst_px", bus.program_x, 0);
        rst = 1'b0;
        @(negedge clk);

        sw = wr_cnt;
        push(20'h00100, 3, 2, 10, 20, 1'b0);
        wait_idle();
        chk("t1_writes", wr_cnt - sw, 6);
        chk("t1_done_gap", last_done_cyc - last_wr_cyc, 1);

        mem[257] = 16'h0000;
        mem[260] = 16'h0000;
        sw = wr_cnt;
        push(20'h00100, 3, 2, 10, 20, 1'b1);
        wait_idle();
        chk("key_writes", wr_cnt - sw, 4);

        sw = wr_cnt;
        sd = done_cnt;
        push(20'h00200, 4, 1, 638, 479, 1'b0);
        wait_idle();
        chk("clip_writes", wr_cnt - sw, 2);
        chk("clip_done", done_cnt - sd, 1);

        push(20'h00300, 0, 5, 1, 1, 1'b0);
        k = 0;
        while (!bus.blit_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("w0_done_lat", k + 1, 3);
        wait_idle();

        sd = done_cnt;
        push(20'h01000, 8, 4, 5, 5, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) push(20'h02000 + 20'(i * 16), 2, 2, 30 + i, 40, 1'b1);
        chk("fifo_full_ready", bus.cmd_ready, 0);
        wait_idle();
        chk("b2b_done", done_cnt - sd, 5);

        push(20'h04000, 16, 16, 100, 100, 1'b0);
        push(20'h05000, 4, 4, 200, 200, 1'b0);
        push(20'h06000, 4, 4, 300, 300, 1'b0);
        repeat (30) @(negedge clk);
        bus.abort      = 1'b1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_src    = 20'h07000;
        bus.cmd_w      = 10'd2;
        bus.cmd_h      = 10'd2;
        @(posedge clk);
        #1;
        bus.abort     = 1'b0;
        bus.cmd_valid = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        sw = wr_cnt;
        sd = done_cnt;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_ready", bus.cmd_ready, 1);
        repeat (40) @(negedge clk);
        chk("abort_writes", wr_cnt - sw, 0);
        chk("abort_dones", done_cnt - sd, 0);
        last_end = bus.src_addr;

        sd = done_cnt;
        for (int n = 0; n < 25; n++) begin
            w   = $urandom_range(0, 10);
            h   = $urandom_range(0, 5);
            x   = ($urandom_range(0, 3) == 0) ? $urandom_range(600, 1023) : $urandom_range(0, 639);
            y   = ($urandom_range(0, 3) == 0) ? $urandom_range(440, 1023) : $urandom_range(0, 479);
            src = 20'($urandom);
            if (src == last_end) src = src + 20'd64;
            push(src, w, h, x, y, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 6)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) wait_idle();
        end
        wait_idle();
        chk("rand_done", done_cnt - sd, 25);
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
        chk("end_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/blit_sequencer.md
Name: blit_sequencer

Overview:
- Hardware sequencer for the copy-engine datapath: executes queued rectangular blits (sprite copies) from the sprite/background store into the frame-buffer write port.
- Each command copies a W×H block from a linear source address to screen position (X,Y).
- Applies a transparency key and clips at the screen edges.
- Sits between the NIOS-side command interface and the frame-buffer programming port (program_x/y/data/write), replacing per-pixel software writes.

Parameters:
- SRC_AW, 20, source address width
- DW, 16, pixel data width
- CW, 10, coordinate/size width
- SCREEN_W, 640, visible width in pixels; writes with x >= SCREEN_W are suppressed
- SCREEN_H, 480, visible height in pixels; writes with y >= SCREEN_H are suppressed
- SRC_LAT, 2, fixed source read latency in cycles (1..4)
- QDEPTH, 4, command FIFO depth (power of two)
- KEY, 16'h0000, transparent pixel value

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_src  in  SRC_AW  source base address
- cmd_w  in  CW  block width
- cmd_h  in  CW  block height
- cmd_x  in  CW  destination x
- cmd_y  in  CW  destination y
- cmd_key_en  in  1  enable transparency
- abort  in  1  synchronous flush of FIFO and active blit
- src_addr  out  SRC_AW  source read address
- src_data  in  DW  source data, valid SRC_LAT cycles after src_addr
- program_x  out  CW  frame-buffer x
- program_y  out  CW  frame-buffer y
- program_data  out  DW  pixel
- program_write  out  1  write strobe, one pixel per cycle
- busy  out  1  FIFO non-empty, FSM not IDLE, or pipeline not empty
- blit_done  out  1  one-cycle pulse per completed command

Behaviour:
- Reset values:
  - All outputs 0, except cmd_ready = 1.
  - FIFO empty; FSM in IDLE.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pop only in the IDLE→LOAD transition.
  - A push and a pop in the same cycle are both honoured.
- FSM states:
  - IDLE: if FIFO non-empty → LOAD.
  - LOAD: latch the head command; reset col = 0, row = 0; set row_base = cmd_src.
    - If w == 0 or h == 0 → DONE, with no reads and no writes.
    - Otherwise → RUN.
  - RUN: issue one read per cycle.
    - src_addr = row_base + col.
    - Tag the pipeline with (x+col, y+row, inb, last).
    - inb = (x+col < SCREEN_W) && (y+row < SCREEN_H), computed at CW+1 bits with no wrap.
    - col increments each cycle.
    - At col == w-1: col ← 0, row ← row+1, row_base ← row_base + w. No multiplier.
    - After issuing (w-1, h-1) → DRAIN.
  - DRAIN: wait until the tagged last beat exits the pipeline → DONE.
  - DONE: pulse blit_done for 1 cycle → IDLE.
- Minimum overhead between back-to-back commands: IDLE + LOAD + DONE = 3 cycles.
- Read pipeline:
  - SRC_LAT-deep shift register of tags.
  - At pipeline exit: program_write = tag_valid && inb && !(key_en && src_data == KEY).
  - program_x, program_y, program_data are registered and change only when program_write = 1.
  - Write latency from src_addr issue: SRC_LAT+1 cycles.
- Arithmetic:
  - src_addr wraps modulo 2^SRC_AW.
  - Coordinates never wrap: an out-of-range pixel is suppressed.
- abort:
  - Clears the FIFO and all pipeline tag_valid bits; FSM → IDLE.
  - No blit_done pulse and no further program_write from the next cycle onward.
  - abort has priority over a same-cycle push; that push is discarded.
- Reset mid-blit: everything returns to reset values immediately; in-flight data is discarded.

Decomposition:
- Package blit_pkg:
  - blit_cmd_t struct {src, w, h, x, y, key_en}.
  - State enum {IDLE, LOAD, RUN, DRAIN, DONE}.
  - pipe_tag_t struct {valid, x, y, inb, last}.
  - SCREEN_W, SCREEN_H and KEY defaults.
- Sub-module blit_cmd_fifo: parameterised synchronous FIFO of blit_cmd_t with a flush input.

Test Plan:
- cmd 3×2 at (10,20), src = 0x00100, key off, SRC_LAT = 2:
  - src_addr sequence 0x100, 0x101, 0x102, 0x103, 0x104, 0x105.
  - 6 writes at (10..12, 20..21) with matching data.
  - blit_done pulse 1 cycle after the last write.
- Same cmd, key on, src_data = 0x0000 at offset 1 and 4: exactly 4 writes; (11,20) and (11,21) are skipped.
- cmd 4×1 at (638,479): writes only at (638,479) and (639,479); 4 reads still issued; blit_done is asserted.
- cmd w = 0: no src_addr change, no writes; blit_done pulse 3 cycles after the push.
- Five back-to-back pushes with QDEPTH = 4 while the first blit is active:
  - cmd_ready drops once the FIFO is full.
  - All accepted commands complete in order, with 5 blit_done pulses total.
- abort asserted mid-RUN of a 16×16 blit with 2 commands queued:
  - No program_write from the cycle after abort onward.
  - No blit_done pulse; busy = 0 within 1 cycle.
  - cmd_ready = 1.
